// File: rtl/xmt_fifo.sv
// Serial line transmitter with an input FIFO: start bit, LSB-first data, optional
// parity, 1 or 2 stop bits, programmable bit time. Line idles high.
module xmt_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          bit_len,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 serial_out
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_C  = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [3:0]          LAST_IDX = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] w, input logic odd);
    return (^w) ^ odd;
  endfunction

  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic                  full_q, empty_q;
  logic                  pop, push;

  state_t                state_q;
  logic [15:0]           timer_q, blen_q;
  logic [3:0]            bit_idx_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  par_q, par_en_q, stop2_q, stop_cnt_q, tx_q;

  // The IDLE pop frees a slot on the same edge, so a write while full is accepted then.
  assign pop  = (state_q == IDLE) && !empty_q;
  assign push = wr_en && (!full_q || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!empty_q) begin
            shift_q  <= mem_q[rd_ptr_q];
            blen_q   <= bit_len;
            timer_q  <= bit_len;
            par_en_q <= parity_mode[0] ^ parity_mode[1];
            par_q    <= parity_bit(mem_q[rd_ptr_q], parity_mode[1]);
            stop2_q  <= stop2;
            tx_q     <= 1'b0;
            state_q  <= START;
          end
        end
        START: begin
          if (timer_q == '0) begin
            timer_q   <= blen_q;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        DATA: begin
          if (timer_q == '0) begin
            timer_q <= blen_q;
            if (bit_idx_q == LAST_IDX) begin
              stop_cnt_q <= 1'b0;
              if (par_en_q) begin
                tx_q    <= par_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        PARITY: begin
          if (timer_q == '0) begin
            timer_q <= blen_q;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        STOP: begin
          if (timer_q == '0) begin
            if (stop2_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
              timer_q    <= blen_q;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign busy       = (state_q != IDLE);
  assign serial_out = tx_q;

endmodule
